alu_serial: RTL and testbench

//  Digit-serial ALU for the multicycle RISC-V datapath; consumes the 3-bit ALUControl code

---
 rtl/alu_serial.sv | 185 ++++++++++++++++++
 tb/tb_alu_serial.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// alu_serial -- digit-serial ALU for the multicycle RISC-V datapath.
// Executes one 3-bit ALUControl operation over NCYC = WIDTH/DIGIT busy cycles
// using a single DIGIT-wide adder slice and a carry flop.
//
// Ports:
//   clk, reset_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      request handshake (in_ready high only in IDLE)
//   ALUControl, SrcA, SrcB   opcode and operands, latched on the accept edge
//   out_valid / out_ready    result handshake (out_valid high only in DONE)
//   ALUResult, Zero          registered result and (ALUResult == 0)
//
// Opcodes: 000 add, 001 sub, 010 and, 011 or, 101 slt, 100 xor.
// XOR exists only when ALU_SERIAL_XOR_EN is defined; otherwise 100, 110 and
// 111 are unsupported and yield ALUResult = 0, Zero = 1 with normal latency.
module alu_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int unsigned NCYC = WIDTH / DIGIT;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101
  } alu_op_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_a_d;
  logic [DIGIT-1:0] w_b_d;
  logic [DIGIT-1:0] w_b_eff;
  logic             w_subtract;
  logic [DIGIT:0]   w_sum;
  logic [DIGIT-1:0] w_dig;
  logic             w_supported;
  logic             w_n;
  logic             w_v;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_final;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(NCYC - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  // ---------------------------------------------------------------- digit slice
  assign w_a_d      = r_a[DIGIT-1:0];
  assign w_b_d      = r_b[DIGIT-1:0];
  assign w_subtract = (r_op == OP_SUB) || (r_op == OP_SLT);
  // Subtraction is A + ~B + 1: the +1 comes from the carry flop preset at accept.
  assign w_b_eff    = w_subtract ? ~w_b_d : w_b_d;
  assign w_sum      = {1'b0, w_a_d} + {1'b0, w_b_eff} + {{DIGIT{1'b0}}, r_carry};

  always_comb begin
    w_dig       = '0;
    w_supported = 1'b1;
    case (r_op)
      OP_ADD, OP_SUB, OP_SLT: w_dig = w_sum[DIGIT-1:0];
      OP_AND:                 w_dig = w_a_d & w_b_d;
      OP_OR:                  w_dig = w_a_d | w_b_d;
`ifdef ALU_SERIAL_XOR_EN
      OP_XOR:                 w_dig = w_a_d ^ w_b_d;
`endif
      default:                w_supported = 1'b0;
    endcase
  end

  // Result digits enter at the MSB end so the LSB digit ends up at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_single_digit
      assign w_res_next = w_dig;
    end else begin : g_multi_digit
      assign w_res_next = {w_dig, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Sign and overflow are only meaningful on the MSB digit, i.e. when w_last.
  assign w_n = w_sum[DIGIT-1];
  assign w_v = (w_a_d[DIGIT-1] != w_b_d[DIGIT-1]) && (w_sum[DIGIT-1] != w_a_d[DIGIT-1]);

  always_comb begin
    w_final = '0;
    if (w_supported) begin
      if (r_op == OP_SLT) begin
        w_final[0] = w_n ^ w_v;
      end else begin
        w_final = w_res_next;
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_op      <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else if (w_accept) begin
      r_a     <= SrcA;
      r_b     <= SrcB;
      r_res   <= '0;
      r_op    <= ALUControl;
      r_carry <= (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_sum[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        ALUResult <= w_final;
        Zero      <= (w_final == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial -- directed bench for alu_serial. Three instances share the
// request inputs and out_ready: DIGIT=4 (8 cycles), DIGIT=1 (32 cycles) and
// DIGIT=32 (1 cycle). Each operation is held in DONE until all three finish.
module tb_alu_serial;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_ready;

  logic        ir4, ir1, ir32;
  logic        ov4, ov1, ov32;
  logic [31:0] res4, res1, res32;
  logic        z4, z1, z32;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_serial #(.WIDTH(32), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir4),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(ov4),
    .out_ready(out_ready), .ALUResult(res4), .Zero(z4)
  );

  alu_serial #(.WIDTH(32), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(ov1),
    .out_ready(out_ready), .ALUResult(res1), .Zero(z1)
  );

  alu_serial #(.WIDTH(32), .DIGIT(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir32),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(ov32),
    .out_ready(out_ready), .ALUResult(res32), .Zero(z32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_z, input bit ack);
    int unsigned lat4, lat1, lat32;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    check({tag, " ready"}, {29'd0, ir4, ir1, ir32}, 32'h7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA     = ~a;  // must not affect the latched operation
    SrcB     = ~b;
    ALUControl = 3'b011;
    check({tag, " busy"}, {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h0);
    lat4 = 0; lat1 = 0; lat32 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ov4  && lat4  == 0) lat4  = n;
      if (ov1  && lat1  == 0) lat1  = n;
      if (ov32 && lat32 == 0) lat32 = n;
      if (lat4 != 0 && lat1 != 0 && lat32 != 0) break;
    end
    check({tag, " lat d4"},  lat4,  32'd8);
    check({tag, " lat d1"},  lat1,  32'd32);
    check({tag, " lat d32"}, lat32, 32'd1);
    check({tag, " res d4"},  res4,  exp_res);
    check({tag, " res d1"},  res1,  exp_res);
    check({tag, " res d32"}, res32, exp_res);
    check({tag, " zero d4"},  {31'd0, z4},  {31'd0, exp_z});
    check({tag, " zero d1"},  {31'd0, z1},  {31'd0, exp_z});
    check({tag, " zero d32"}, {31'd0, z32}, {31'd0, exp_z});
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " idle"}, {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h38);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    #2;
    check("reset hs",  {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h38);
    check("reset res", res4 | res1 | res32, 32'h0);
    check("reset z",   {29'd0, z4, z1, z32}, 32'h0);
    #10 reset_n = 1'b1;
    @(negedge clk);

    do_op("add",      3'b000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b1);
    do_op("sub eq",   3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1);
    do_op("add wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    do_op("sub neg",  3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b1);
    do_op("slt m1",   3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
    do_op("slt ovf",  3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
    do_op("slt max",  3'b101, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    do_op("slt 3<5",  3'b101, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b1);
    do_op("or",       3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b1);
    do_op("op111",    3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1);
    do_op("op110",    3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
`ifdef ALU_SERIAL_XOR_EN
    do_op("xor",      3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b1);
`else
    do_op("xor off",  3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_0000, 1'b1, 1'b1);
`endif

    // Stall in DONE with a competing request that must be ignored.
    do_op("and stall", 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
    in_valid   = 1'b1;
    ALUControl = 3'b000;
    SrcA       = 32'h0000_0001;
    SrcB       = 32'h0000_0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall res", res4, 32'hF000_F000);
      check("stall hs",  {30'd0, ir4, ov4}, 32'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release", {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h38);
    @(posedge clk); #1;
    check("not queued", {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h38);
    check("hold idle res", res4, 32'hF000_F000);

    // Reset while DIGIT=4 instance is at digit 3.
    ALUControl = 3'b000;
    SrcA       = 32'h0000_1111;
    SrcB       = 32'h0000_2222;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort hs",  {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h38);
    check("abort res", res4 | res1 | res32, 32'h0);
    check("abort z",   {29'd0, z4, z1, z32}, 32'h0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post abort", {26'd0, ir4, ir1, ir32, ov4, ov1, ov32}, 32'h38);
    do_op("add post", 3'b000, 32'h89AB_CDEF, 32'h1111_1111, 32'h9ABC_DF00, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
